register_file_mp: RTL

//  Next-generation MIPS GPR file: N_READ combinational read ports, two write ports
//  (W0 = MEM/WB, W1 = late/multi-cycle unit), optional hardwired $zero, optional

---
 rtl/register_file_mp.sv | 127 ++++++++++++
 1 files changed

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port GPR file with dual write, bypass and busy scoreboard
// Decode-stage register file: combinational reads, two write ports (W1 wins), per-register busy bits.
module register_file_mp #(
    parameter int NB_DATA    = 32,
    parameter int N_REGS     = 32,
    parameter int N_READ     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int RESET_MODE = 1,
    localparam int NB_ADDR   = $clog2(N_REGS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_we0,
    input  logic [NB_ADDR-1:0]          i_waddr0,
    input  logic [NB_DATA-1:0]          i_wdata0,
    input  logic                        i_we1,
    input  logic [NB_ADDR-1:0]          i_waddr1,
    input  logic [NB_DATA-1:0]          i_wdata1,
    input  logic [N_READ*NB_ADDR-1:0]   i_raddr,
    output logic [N_READ*NB_DATA-1:0]   o_rdata,
    output logic [N_READ-1:0]           o_rbusy,
    input  logic                        i_issue,
    input  logic [NB_ADDR-1:0]          i_issue_addr,
    input  logic                        i_flush,
    input  logic [NB_ADDR-1:0]          i_dbg_addr,
    output logic [NB_DATA-1:0]          o_dbg_data,
    output logic [N_REGS-1:0]           o_busy_vec
);

    logic [NB_DATA-1:0] regs_q [N_REGS];
    logic [NB_DATA-1:0] regs_d [N_REGS];
    logic [N_REGS-1:0]  busy_q;
    logic [N_REGS-1:0]  busy_d;
    logic               we0_eff;
    logic               we1_eff;

    function automatic logic [NB_DATA-1:0] rst_val(input int idx);
        if (RESET_MODE == 1 && !(ZERO_REG != 0 && idx == 0)) begin
            return NB_DATA'(idx);
        end
        return '0;
    endfunction

    // Effective enables drop $zero writes and anything while reset is held,
    // so bypass and scoreboard never see a write that will not land.
    always_comb begin
        we0_eff = i_we0 && !i_rst && !(ZERO_REG != 0 && i_waddr0 == '0);
        we1_eff = i_we1 && !i_rst && !(ZERO_REG != 0 && i_waddr1 == '0);
    end

    always_comb begin
        for (int i = 0; i < N_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (we0_eff && i_waddr0 == NB_ADDR'(i)) begin
                regs_d[i] = i_wdata0;
            end
            if (we1_eff && i_waddr1 == NB_ADDR'(i)) begin
                regs_d[i] = i_wdata1;
            end
        end
    end

    // Later assignments take priority: flush > issue > write-clear > hold.
    always_comb begin
        for (int i = 0; i < N_REGS; i++) begin
            busy_d[i] = busy_q[i];
            if ((we0_eff && i_waddr0 == NB_ADDR'(i)) ||
                (we1_eff && i_waddr1 == NB_ADDR'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (i_issue && i_issue_addr == NB_ADDR'(i)) begin
                busy_d[i] = 1'b1;
            end
            if (i_flush) begin
                busy_d[i] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= rst_val(i);
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < N_READ; k++) begin : g_rd
        logic [NB_ADDR-1:0] raddr;
        logic [NB_DATA-1:0] rdata;
        logic               rbusy;
        logic               hit0;
        logic               hit1;

        assign raddr = i_raddr[k*NB_ADDR +: NB_ADDR];

        // A forwarded write also satisfies the pending producer, so busy drops.
        always_comb begin
            hit0  = (BYPASS != 0) && we0_eff && (i_waddr0 == raddr);
            hit1  = (BYPASS != 0) && we1_eff && (i_waddr1 == raddr);
            rdata = regs_q[raddr];
            if (hit1) begin
                rdata = i_wdata1;
            end else if (hit0) begin
                rdata = i_wdata0;
            end
            rbusy = busy_q[raddr] && !(hit0 || hit1);
        end

        assign o_rdata[k*NB_DATA +: NB_DATA] = rdata;
        assign o_rbusy[k]                    = rbusy;
    end

    assign o_dbg_data = regs_q[i_dbg_addr];
    assign o_busy_vec = busy_q;

endmodule
